// File: rtl/ad7276_capture_sequencer.sv
// rtl/ad7276_capture_sequencer.sv - dual-channel AD7276 frame sequencer feeding a packetised AXI-Stream master
// Optional AD7276_TEST_PATTERN_EN replaces ADC data with a frame sequence number when TestPatternSel=1.
module ad7276_capture_sequencer #(
  parameter int SCLK_DIV     = 2,
  parameter int CONV_BITS    = 16,
  parameter int QUIET_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        EnableSampleGeneration,
  input  logic [31:0] PacketSize,
  input  logic [31:0] PacketRate,
  input  logic [1:0]  inData,
`ifdef AD7276_TEST_PATTERN_EN
  input  logic        TestPatternSel,
`endif
  output logic        cs,
  output logic        sclk,
  output logic        M_AXIS_TVALID,
  output logic [31:0] M_AXIS_TDATA,
  output logic [3:0]  M_AXIS_TSTRB,
  output logic [3:0]  M_AXIS_TKEEP,
  output logic        M_AXIS_TLAST,
  output logic        M_AXIS_TUSER,
  input  logic        M_AXIS_TREADY,
  output logic [31:0] DroppedSamples,
  output logic        Busy
);

  localparam logic [31:0] MINP = 32'(2 * SCLK_DIV * CONV_BITS + QUIET_CYCLES);
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = $clog2(CONV_BITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CONVERT, S_PUSH} state_t;

  state_t          r_state, w_next;
  logic [31:0]     r_rate;
  logic [DW-1:0]   r_div;
  logic [BW-1:0]   r_bits;
  logic            r_sclk;
  logic [15:0]     r_sh0, r_sh1;
  logic [31:0]     r_size, r_beat;
  logic            r_valid, r_last, r_user, r_pend;
  logic [31:0]     r_data, r_drop;

  logic [31:0]     w_period, w_size_in, w_adc_data, w_beat_data;
  logic            w_wrap, w_div_end, w_rise, w_frame_done;
  logic            w_push, w_load, w_last;
  logic            w_unused;

  assign w_period     = (PacketRate > MINP) ? PacketRate : MINP;
  assign w_size_in    = (PacketSize == 32'd0) ? 32'd1 : PacketSize;
  assign w_wrap       = (r_rate >= w_period - 32'd1);
  assign w_div_end    = (r_div == DW'(SCLK_DIV - 1));
  assign w_rise       = (r_state == S_CONVERT) && w_div_end && !r_sclk;
  assign w_frame_done = w_rise && (r_bits == BW'(CONV_BITS - 1));
  assign w_push       = (r_state == S_PUSH);
  assign w_load       = w_push && (!r_valid || M_AXIS_TREADY);
  assign w_last       = (r_beat == r_size - 32'd1);
  assign w_adc_data   = {4'h0, r_sh1[13:2], 4'h0, r_sh0[13:2]};
  assign w_unused     = &{1'b0, r_sh0[15:14], r_sh0[1:0], r_sh1[15:14], r_sh1[1:0]};

`ifdef AD7276_TEST_PATTERN_EN
  logic [31:0] r_seq;
  assign w_beat_data = TestPatternSel ? r_seq : w_adc_data;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_seq <= 32'd0;
    end else if (w_push) begin
      r_seq <= r_seq + 32'd1;
    end
  end
`else
  assign w_beat_data = w_adc_data;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    cs     = 1'b1;
    Busy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        Busy = 1'b0;
        if (EnableSampleGeneration) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_wrap) w_next = S_CONVERT;
      end
      S_CONVERT: begin
        cs = 1'b0;
        if (w_frame_done) w_next = S_PUSH;
      end
      S_PUSH: begin
        // Stop only once the packet's TLAST beat is actually in the output register.
        w_next = (w_load && w_last && !EnableSampleGeneration) ? S_IDLE : S_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rate  <= 32'd0;
      r_div   <= '0;
      r_bits  <= '0;
      r_sclk  <= 1'b1;
      r_sh0   <= 16'd0;
      r_sh1   <= 16'd0;
      r_size  <= 32'd1;
      r_beat  <= 32'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_user  <= 1'b0;
      r_pend  <= 1'b0;
      r_data  <= 32'd0;
      r_drop  <= 32'd0;
    end else begin
      // Preloading P-1 in IDLE makes the first WAIT cycle a wrap.
      if (r_state == S_IDLE) begin
        r_rate <= w_period - 32'd1;
      end else if (w_wrap) begin
        r_rate <= 32'd0;
      end else begin
        r_rate <= r_rate + 32'd1;
      end

      if (r_state == S_IDLE && EnableSampleGeneration) begin
        r_size <= w_size_in;
        r_beat <= 32'd0;
      end

      if (r_state == S_WAIT) begin
        r_div  <= '0;
        r_bits <= '0;
        r_sclk <= 1'b1;
      end else if (r_state == S_CONVERT) begin
        if (w_div_end) begin
          r_div  <= '0;
          r_sclk <= ~r_sclk;
          if (w_rise) begin
            r_sh0  <= {r_sh0[14:0], inData[0]};
            r_sh1  <= {r_sh1[14:0], inData[1]};
            r_bits <= r_bits + BW'(1);
          end
        end else begin
          r_div <= r_div + DW'(1);
        end
      end

      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_beat_data;
        r_last  <= w_last;
        r_user  <= r_pend;
        r_pend  <= 1'b0;
        if (w_last) begin
          r_beat <= 32'd0;
          r_size <= w_size_in;
        end else begin
          r_beat <= r_beat + 32'd1;
        end
      end else if (M_AXIS_TREADY) begin
        r_valid <= 1'b0;
      end

      if (w_push && !w_load) begin
        r_pend <= 1'b1;
        if (r_drop != 32'hFFFF_FFFF) r_drop <= r_drop + 32'd1;
      end
    end
  end

  assign sclk           = r_sclk;
  assign M_AXIS_TVALID  = r_valid;
  assign M_AXIS_TDATA   = r_data;
  assign M_AXIS_TLAST   = r_last;
  assign M_AXIS_TUSER   = r_user;
  assign M_AXIS_TSTRB   = 4'hF;
  assign M_AXIS_TKEEP   = 4'hF;
  assign DroppedSamples = r_drop;

endmodule

// File: tb/tb_ad7276_capture_sequencer.sv
// tb/tb_ad7276_capture_sequencer.sv - randomized bench for ad7276_capture_sequencer against a frame-level model
module tb_ad7276_capture_sequencer;
  localparam int SCLK_DIV = 2;
  localparam int CONVC    = 2 * SCLK_DIV * 16;
  localparam int MINP     = CONVC + 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        en = 1'b0;
  logic [31:0] psize = 32'd4;
  logic [31:0] prate = 32'd100;
  logic [1:0]  in_data = 2'b00;
  logic        tready = 1'b1;
  logic        cs, sclk, tvalid, tlast, tuser, busy;
  logic [31:0] tdata, dropped;
  logic [3:0]  tstrb, tkeep;
`ifdef AD7276_TEST_PATTERN_EN
  logic        tp_sel = 1'b0;
`endif

  ad7276_capture_sequencer dut (
    .Clk(Clk), .Reset(Reset), .EnableSampleGeneration(en),
    .PacketSize(psize), .PacketRate(prate), .inData(in_data),
`ifdef AD7276_TEST_PATTERN_EN
    .TestPatternSel(tp_sel),
`endif
    .cs(cs), .sclk(sclk), .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata),
    .M_AXIS_TSTRB(tstrb), .M_AXIS_TKEEP(tkeep), .M_AXIS_TLAST(tlast),
    .M_AXIS_TUSER(tuser), .M_AXIS_TREADY(tready),
    .DroppedSamples(dropped), .Busy(busy)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ADC pin model: a fresh word per frame, AD7276 format {00, data[11:0], 00}, shifted out on sclk falls
  bit          fixed_data = 1'b0;
  logic [11:0] adc_d0, adc_d1;
  logic [15:0] adc_w0, adc_w1;
  int          adc_n;
  logic [11:0] q0[$], q1[$];

  always @(negedge cs) begin
    if (!Reset) begin
      adc_d0 = fixed_data ? 12'hABC : 12'($urandom_range(0, 4095));
      adc_d1 = fixed_data ? 12'h123 : 12'($urandom_range(0, 4095));
      adc_w0 = {2'b00, adc_d0, 2'b00};
      adc_w1 = {2'b00, adc_d1, 2'b00};
      q0.push_back(adc_d0);
      q1.push_back(adc_d1);
      adc_n = 0;
    end
  end

  always @(negedge sclk) begin
    if (cs === 1'b0 && adc_n < 16) begin
      in_data = {adc_w1[15-adc_n], adc_w0[15-adc_n]};
      adc_n++;
    end
  end

  // Frame-level reference: frames start every P cycles from t0, last CONVC cycles, push at phase CONVC
  int          cyc = 0;
  bit          m_on = 1'b0, m_busy = 1'b0;
  int          m_t0, m_P, ph;
  logic [31:0] m_size, m_beat, m_drop, m_data;
  bit          m_valid, m_last, m_user, m_pend, m_push;
  bit          exp_cs, exp_sclk;
  logic [11:0] dd0, dd1;

  always @(negedge Clk) begin
    cyc++;
    ph = cyc - m_t0;
    if (m_on) begin
      exp_cs = 1'b1;
      exp_sclk = 1'b1;
      if (m_busy && ph >= 0 && (ph % m_P) < CONVC) begin
        exp_cs = 1'b0;
        exp_sclk = (((ph % m_P) / SCLK_DIV) % 2) == 0;
      end
      check("cs", 32'(cs), 32'(exp_cs));
      check("sclk", 32'(sclk), 32'(exp_sclk));
      check("busy", 32'(busy), 32'(m_busy));
      check("tvalid", 32'(tvalid), 32'(m_valid));
      check("tdata", tdata, m_data);
      check("tlast", 32'(tlast), 32'(m_last));
      check("tuser", 32'(tuser), 32'(m_user));
      check("dropped", dropped, m_drop);
    end
    if (Reset) begin
      m_on = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_last = 1'b0; m_user = 1'b0;
      m_pend = 1'b0; m_data = 32'd0; m_drop = 32'd0; m_beat = 32'd0; m_size = 32'd1;
      q0.delete(); q1.delete();
    end else if (m_on) begin
      m_push = m_busy && ph >= 0 && (ph % m_P) == CONVC;
      if (m_push) begin
        check("adc_frame_avail", 32'(q0.size() != 0), 32'd1);
        dd0 = (q0.size() != 0) ? q0.pop_front() : 12'h000;
        dd1 = (q1.size() != 0) ? q1.pop_front() : 12'h000;
        if (!m_valid || tready) begin
          m_valid = 1'b1;
          m_data = {4'h0, dd1, 4'h0, dd0};
          m_last = (m_beat == m_size - 1);
          m_user = m_pend;
          m_pend = 1'b0;
          if (m_last) begin
            m_beat = 0;
            m_size = (psize == 0) ? 32'd1 : psize;
            if (!en) m_busy = 1'b0;
          end else begin
            m_beat++;
          end
        end else begin
          m_drop++;
          m_pend = 1'b1;
        end
      end else if (m_valid && tready) begin
        m_valid = 1'b0;
      end
      if (!m_busy && !m_push && en) begin
        m_busy = 1'b1;
        m_t0 = cyc + 2;
        m_P = (prate > MINP) ? int'(prate) : MINP;
        m_size = (psize == 0) ? 32'd1 : psize;
        m_beat = 0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < max_cyc) begin
      cycles(1);
      k++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    cycles(10);
    Reset = 1'b0;
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd1);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_tuser", 32'(tuser), 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_dropped", dropped, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("tstrb", 32'(tstrb), 32'hF);
    check("tkeep", 32'(tkeep), 32'hF);

    // Frame timing and fixed-pattern packing
    fixed_data = 1'b1; prate = 32'd100; psize = 32'd4; tready = 1'b1;
    cycles(5); en = 1'b1;
    cycles(1300); en = 1'b0;
    wait_idle(20000);
    fixed_data = 1'b0;

    // Rate clamp with PacketSize=0 and random backpressure
    prate = 32'd10; psize = 32'd0; en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tready = ($urandom_range(0, 3) != 0);
      cycles(1);
    end
    en = 1'b0; tready = 1'b1;
    wait_idle(20000);

    // Long stall forces drops, then release
    prate = 32'd66; psize = 32'd8; en = 1'b1;
    cycles(200); tready = 1'b0;
    cycles(300); tready = 1'b1;
    cycles(400); en = 1'b0;
    wait_idle(20000);

    // Stop rule with packets longer than the enable window
    psize = 32'd31; en = 1'b1;
    cycles(900); en = 1'b0;
    wait_idle(10000);
    cycles(200);
    psize = 32'd75; en = 1'b1;
    cycles(300); en = 1'b0;
    wait_idle(10000);
    cycles(100);

    // Random enable toggling (covers cancelled stops) and random sizes/ready
    prate = 32'(MINP + $urandom_range(0, 40));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) en = ~en;
      if ($urandom_range(0, 49) == 0) psize = 32'($urandom_range(0, 3));
      tready = ($urandom_range(0, 4) != 0);
      cycles(1);
    end
    en = 1'b0; tready = 1'b1;
    wait_idle(20000);

    // Reset in the middle of a frame after drops have accumulated
    prate = 32'd66; psize = 32'd2; en = 1'b1; tready = 1'b0;
    cycles(400);
    begin
      int k;
      k = 0;
      while (cs !== 1'b0 && k < 200) begin
        cycles(1);
        k++;
      end
    end
    check("midframe_cs_low", 32'(cs), 32'd0);
    cycles(10);
    Reset = 1'b1;
    cycles(1);
    Reset = 1'b0; en = 1'b0; tready = 1'b1;
    check("mid_rst_cs", 32'(cs), 32'd1);
    check("mid_rst_sclk", 32'(sclk), 32'd1);
    check("mid_rst_tvalid", 32'(tvalid), 32'd0);
    check("mid_rst_dropped", dropped, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    cycles(50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
